// File: rtl/nps_pkg.sv
// Shared definitions for the NPS input-memory stage: sequencer state encoding
// and the default memory geometry, so the sequencer and the memory agree.
package nps_pkg;

    localparam int NPS_DATA_WIDTH = 16;
    localparam int NPS_ADR_WIDTH  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/nps_cpu_wr_gate.sv
// CPU write path into the input memory: one register stage, with writes
// dropped (and flagged) while a frame sequence is in progress.
module nps_cpu_wr_gate
    import nps_pkg::*;
#(
    parameter int DATA_WIDTH = NPS_DATA_WIDTH,
    parameter int ADR_WIDTH  = NPS_ADR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  busy,
    input  logic                  cpu_wr,
    input  logic [ADR_WIDTH-1:0]  cpu_adr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  mem_wr,
    output logic [ADR_WIDTH-1:0]  mem_adr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  wr_reject
);

    logic wr_accept;

    assign wr_accept = cpu_wr & ~busy;

    // Strobes: forward accepted writes, pulse reject for writes seen while busy
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mem_wr    <= 1'b0;
            wr_reject <= 1'b0;
        end else begin
            mem_wr    <= wr_accept;
            wr_reject <= cpu_wr & busy;
        end
    end

    // Address register, updated only on accepted writes so the port stays quiet
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mem_adr <= '0;
        end else if (wr_accept) begin
            mem_adr <= cpu_adr;
        end
    end

    // Data register, one flop per bit with the same accept enable
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_bit
        always_ff @(posedge clk or negedge reset_x) begin
            if (!reset_x) begin
                mem_data[gi] <= 1'b0;
            end else if (wr_accept) begin
                mem_data[gi] <= cpu_data[gi];
            end
        end
    end

endmodule

// File: rtl/nps_inmem_seq.sv
// Frame sequencer for the NPS input memory: issues start for N frames with an
// inter-frame gap, checks each frame's beat count and completion, and reports
// busy/done/err status. CPU loads are gated off while a sequence runs.
module nps_inmem_seq
    import nps_pkg::*;
#(
    parameter int DATA_WIDTH  = NPS_DATA_WIDTH,
    parameter int ADR_WIDTH   = NPS_ADR_WIDTH,
    parameter int DATA_NUM    = 30,
    parameter int FRAME_WIDTH = 8,
    parameter int GAP         = 4,
    parameter int TIMEOUT     = 100,
    parameter int TO_WIDTH    = 7
) (
    input  logic                   clk,
    input  logic                   reset_x,
    input  logic [ADR_WIDTH-1:0]   cpu_adr,
    input  logic [DATA_WIDTH-1:0]  cpu_data,
    input  logic                   cpu_wr,
    input  logic                   cpu_run,
    input  logic [FRAME_WIDTH-1:0] cpu_frames,
    input  logic                   cpu_abort,
    output logic [ADR_WIDTH-1:0]   mem_adr,
    output logic [DATA_WIDTH-1:0]  mem_data,
    output logic                   mem_wr,
    output logic                   mem_start,
    input  logic                   mem_vo,
    input  logic                   mem_fo,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   wr_reject,
    output logic [FRAME_WIDTH-1:0] frame_cnt
);

    localparam int BEAT_WIDTH = $clog2(DATA_NUM + 1);
    localparam int GAP_WIDTH  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BEAT_WIDTH-1:0] BEAT_EXPECT = BEAT_WIDTH'(DATA_NUM);
    localparam logic [TO_WIDTH-1:0]   TO_LAST     = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [GAP_WIDTH-1:0]  GAP_LAST    = GAP_WIDTH'(GAP - 1);

    seq_state_t             state_reg;
    logic [FRAME_WIDTH-1:0] frames_reg;
    logic [BEAT_WIDTH-1:0]  beat_cnt_reg;
    logic [TO_WIDTH-1:0]    to_cnt_reg;
    logic [GAP_WIDTH-1:0]   gap_cnt_reg;

    logic [BEAT_WIDTH-1:0]  beat_cnt_next;
    logic [FRAME_WIDTH-1:0] frame_cnt_next;

    // Beat count including the current cycle's vo, saturating at all-ones
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (mem_vo && (beat_cnt_reg != '1)) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
        end
    end

    assign frame_cnt_next = frame_cnt + 1'b1;

    // Sequencer FSM with registered status/start outputs and frame counters
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_reg    <= ST_IDLE;
            frames_reg   <= '0;
            beat_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            gap_cnt_reg  <= '0;
            frame_cnt    <= '0;
            mem_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else if (cpu_abort && (state_reg != ST_IDLE)) begin
            // Abort beats any pending fo; frame_cnt and err are left as they are
            state_reg <= ST_IDLE;
            mem_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    mem_start <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (cpu_run) begin
                        if (cpu_frames != '0) begin
                            frames_reg <= cpu_frames;
                            frame_cnt  <= '0;
                            err        <= 1'b0;
                            mem_start  <= 1'b1;
                            busy       <= 1'b1;
                            state_reg  <= ST_START;
                        end else begin
                            // Empty sequence completes immediately
                            done <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    mem_start    <= 1'b0;
                    beat_cnt_reg <= '0;
                    to_cnt_reg   <= '0;
                    state_reg    <= ST_WAIT;
                end

                ST_WAIT: begin
                    beat_cnt_reg <= beat_cnt_next;
                    to_cnt_reg   <= to_cnt_reg + 1'b1;
                    if (mem_fo) begin
                        if (beat_cnt_next != BEAT_EXPECT) begin
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= ST_ERR;
                        end else begin
                            frame_cnt <= frame_cnt_next;
                            if (frame_cnt_next == frames_reg) begin
                                done      <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                gap_cnt_reg <= '0;
                                state_reg   <= ST_GAP;
                            end
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_ERR;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        mem_start <= 1'b1;
                        state_reg <= ST_START;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                ST_ERR: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    mem_start <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    nps_cpu_wr_gate #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADR_WIDTH  (ADR_WIDTH)
    ) u_wr_gate (
        .clk       (clk),
        .reset_x   (reset_x),
        .busy      (busy),
        .cpu_wr    (cpu_wr),
        .cpu_adr   (cpu_adr),
        .cpu_data  (cpu_data),
        .mem_wr    (mem_wr),
        .mem_adr   (mem_adr),
        .mem_data  (mem_data),
        .wr_reject (wr_reject)
    );

endmodule

// File: tb/tb_nps_inmem_seq.sv
// Directed bench for nps_inmem_seq with a small behavioural memory that
// answers each start with a programmable number of vo beats and an optional fo.
module tb_nps_inmem_seq;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int FW  = 8;
    // START + 30 WAIT cycles + 4 GAP cycles between consecutive start pulses
    localparam int FRAME_PERIOD = 35;
    // start pulse cycle -> first err cycle: 1 START + 100 WAIT cycles
    localparam int TO_LATENCY   = 101;

    logic          clk = 1'b0;
    logic          reset_x;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_data;
    logic          cpu_wr;
    logic          cpu_run;
    logic [FW-1:0] cpu_frames;
    logic          cpu_abort;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_data;
    logic          mem_wr;
    logic          mem_start;
    logic          mem_vo;
    logic          mem_fo;
    logic          busy;
    logic          done;
    logic          err;
    logic          wr_reject;
    logic [FW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model controls (written by the stimulus only)
    int m_beats = 30;
    bit m_fo_en = 1'b1;
    int m_cnt   = 0;
    bit m_active = 1'b0;

    // monitor state (written by the monitor only)
    int start_cnt = 0;
    int done_cnt  = 0;
    int rej_cnt   = 0;
    int last_start_cyc = -1;
    int err_rise_cyc   = 0;
    bit err_prev = 1'b0;
    int ivals[$];

    nps_inmem_seq dut (
        .clk        (clk),
        .reset_x    (reset_x),
        .cpu_adr    (cpu_adr),
        .cpu_data   (cpu_data),
        .cpu_wr     (cpu_wr),
        .cpu_run    (cpu_run),
        .cpu_frames (cpu_frames),
        .cpu_abort  (cpu_abort),
        .mem_adr    (mem_adr),
        .mem_data   (mem_data),
        .mem_wr     (mem_wr),
        .mem_start  (mem_start),
        .mem_vo     (mem_vo),
        .mem_fo     (mem_fo),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr_reject  (wr_reject),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: vo on consecutive cycles after start, fo with the last beat
    always @(negedge clk) begin
        mem_vo = 1'b0;
        mem_fo = 1'b0;
        if (!reset_x) begin
            m_active = 1'b0;
        end else if (mem_start) begin
            m_active = 1'b1;
            m_cnt    = 0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt <= m_beats) mem_vo = 1'b1;
            if (m_fo_en && (m_cnt == m_beats)) begin
                mem_fo   = 1'b1;
                m_active = 1'b0;
            end
        end
    end

    // Output monitor: pulse counters, start spacing and err rise time
    always @(negedge clk) begin
        if (mem_start) begin
            if (last_start_cyc >= 0) ivals.push_back(cyc - last_start_cyc);
            last_start_cyc = cyc;
            start_cnt++;
        end
        if (done)      done_cnt++;
        if (wr_reject) rej_cnt++;
        if (err && !err_prev) err_rise_cyc = cyc;
        err_prev = err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse cpu_run for one cycle; on return the first post-run edge has passed
    task automatic run_seq(input logic [FW-1:0] frames);
        cpu_run    = 1'b1;
        cpu_frames = frames;
        step();
        cpu_run    = 1'b0;
        cpu_frames = '0;
        $display("run frames=%0d busy=%0b start=%0b", frames, busy, mem_start);
    endtask

    initial begin
        int s0, d0, r0;
        reset_x    = 1'b0;
        cpu_adr    = '0;
        cpu_data   = '0;
        cpu_wr     = 1'b0;
        cpu_run    = 1'b0;
        cpu_frames = '0;
        cpu_abort  = 1'b0;
        mem_vo     = 1'b0;
        mem_fo     = 1'b0;

        // reset state
        step(3);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_start", 32'(mem_start), 32'd0);
        chk("rst_wr",    32'(mem_wr), 32'd0);
        chk("rst_fcnt",  32'(frame_cnt), 32'd0);
        reset_x = 1'b1;
        step(2);

        // load addresses 0..29 in IDLE, each mirrored one cycle later
        for (int i = 0; i < 30; i++) begin
            cpu_wr   = 1'b1;
            cpu_adr  = AW'(i);
            cpu_data = DW'(16'hA000 + i * 3);
            step();
            cpu_wr = 1'b0;
            $display("write adr=%0d data=%0h mem_wr=%0b", i, cpu_data, mem_wr);
            chk("load_wr",   32'(mem_wr), 32'd1);
            chk("load_adr",  32'(mem_adr), 32'(i));
            chk("load_data", 32'(mem_data), 32'(16'hA000 + i * 3));
            step();
            chk("load_wr_lo", 32'(mem_wr), 32'd0);
        end

        // three-frame sequence
        s0 = start_cnt; d0 = done_cnt;
        run_seq(8'd3);
        chk("run3_busy",  32'(busy), 32'd1);
        chk("run3_start", 32'(mem_start), 32'd1);
        step();
        chk("run3_start_1cyc", 32'(mem_start), 32'd0);
        step(150);
        chk("run3_starts", 32'(start_cnt - s0), 32'd3);
        chk("run3_done",   32'(done_cnt - d0), 32'd1);
        chk("run3_fcnt",   32'(frame_cnt), 32'd3);
        chk("run3_err",    32'(err), 32'd0);
        chk("run3_busy_lo", 32'(busy), 32'd0);
        chk("run3_ival_a", 32'(ivals[ivals.size()-2]), 32'(FRAME_PERIOD));
        chk("run3_ival_b", 32'(ivals[ivals.size()-1]), 32'(FRAME_PERIOD));

        // zero frames: immediate done, nothing started
        s0 = start_cnt; d0 = done_cnt;
        run_seq(8'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        chk("zero_done_1cyc", 32'(done), 32'd0);
        step(5);
        chk("zero_starts", 32'(start_cnt - s0), 32'd0);
        chk("zero_fcnt",   32'(frame_cnt), 32'd3);

        // write during busy is dropped and flagged
        r0 = rej_cnt; d0 = done_cnt;
        run_seq(8'd1);
        step(5);
        cpu_wr = 1'b1; cpu_adr = 5'd5; cpu_data = 16'h1234;
        step();
        cpu_wr = 1'b0;
        $display("busy write adr=5 mem_wr=%0b reject=%0b", mem_wr, wr_reject);
        chk("bwr_mem_wr", 32'(mem_wr), 32'd0);
        chk("bwr_reject", 32'(wr_reject), 32'd1);
        step();
        chk("bwr_reject_1cyc", 32'(wr_reject), 32'd0);
        step(50);
        chk("bwr_rej_cnt", 32'(rej_cnt - r0), 32'd1);
        chk("bwr_done",    32'(done_cnt - d0), 32'd1);
        cpu_wr = 1'b1; cpu_adr = 5'd7; cpu_data = 16'hBEEF;
        step();
        cpu_wr = 1'b0;
        chk("idle_wr",  32'(mem_wr), 32'd1);
        chk("idle_adr", 32'(mem_adr), 32'd7);
        chk("idle_data", 32'(mem_data), 32'hBEEF);

        // beat mismatch: 29 beats then fo
        m_beats = 29;
        s0 = start_cnt; d0 = done_cnt;
        run_seq(8'd2);
        step(60);
        $display("mismatch err=%0b busy=%0b", err, busy);
        chk("bm_err",    32'(err), 32'd1);
        chk("bm_busy",   32'(busy), 32'd0);
        chk("bm_done",   32'(done_cnt - d0), 32'd0);
        chk("bm_starts", 32'(start_cnt - s0), 32'd1);
        m_beats = 30;
        d0 = done_cnt;
        run_seq(8'd1);
        chk("bm_err_clr", 32'(err), 32'd0);
        step(50);
        chk("bm_recover_done", 32'(done_cnt - d0), 32'd1);

        // timeout: fo never arrives
        m_fo_en = 1'b0;
        d0 = done_cnt;
        run_seq(8'd1);
        step(130);
        $display("timeout err=%0b latency=%0d", err, err_rise_cyc - last_start_cyc);
        chk("to_err",     32'(err), 32'd1);
        chk("to_latency", 32'(err_rise_cyc - last_start_cyc), 32'(TO_LATENCY));
        chk("to_busy",    32'(busy), 32'd0);
        chk("to_done",    32'(done_cnt - d0), 32'd0);
        m_fo_en = 1'b1;

        // abort in the gap after frame 1 of 4
        s0 = start_cnt; d0 = done_cnt;
        run_seq(8'd4);
        step(32);
        cpu_abort = 1'b1;
        step();
        cpu_abort = 1'b0;
        $display("abort busy=%0b frame_cnt=%0d", busy, frame_cnt);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_fcnt", 32'(frame_cnt), 32'd1);
        step(60);
        chk("ab_starts", 32'(start_cnt - s0), 32'd1);
        chk("ab_done",   32'(done_cnt - d0), 32'd0);
        chk("ab_err",    32'(err), 32'd0);

        // abort in IDLE has no effect
        cpu_abort = 1'b1;
        step();
        cpu_abort = 1'b0;
        chk("ab_idle_fcnt", 32'(frame_cnt), 32'd1);

        // asynchronous reset during WAIT of frame 2
        d0 = done_cnt;
        run_seq(8'd2);
        step(45);
        chk("pre_rst_fcnt", 32'(frame_cnt), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset_x = 1'b0;
        #1;
        $display("async reset busy=%0b frame_cnt=%0d", busy, frame_cnt);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fcnt", 32'(frame_cnt), 32'd0);
        chk("arst_start", 32'(mem_start), 32'd0);
        chk("arst_err",  32'(err), 32'd0);
        step(2);
        reset_x = 1'b1;
        step(60);
        chk("arst_done", 32'(done_cnt - d0), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nps_inmem_seq.md
Name: nps_inmem_seq

Overview:
Frame sequencer for the NPS input-memory stage. Owns the memory's CPU write port and start input. Gates CPU loads so they cannot disturb a stream in flight, and issues start for N frames with a configurable inter-frame gap. Checks each frame's valid-beat count and completion flag, and reports busy/done/error status to the CPU.

Parameters:
DATA_WIDTH, 16, memory word width
ADR_WIDTH, 5, memory address width
DATA_NUM, 30, expected vo beats per frame
FRAME_WIDTH, 8, width of frame counter
GAP, 4, idle cycles between frames (>=1)
TIMEOUT, 100, max cycles from start to fo before error
TO_WIDTH, 7, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset_x  in  1  asynchronous active-low reset
cpu_adr  in  ADR_WIDTH  CPU load address
cpu_data  in  DATA_WIDTH  CPU load data
cpu_wr  in  1  CPU load strobe
cpu_run  in  1  pulse: begin sequence
cpu_frames  in  FRAME_WIDTH  frames to run, sampled with cpu_run
cpu_abort  in  1  pulse: abandon sequence
mem_adr  out  ADR_WIDTH  to memory cpu_adr
mem_data  out  DATA_WIDTH  to memory cpu_data
mem_wr  out  1  to memory cpu_wr
mem_start  out  1  to memory start
mem_vo  in  1  memory valid out
mem_fo  in  1  memory frame-end flag
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, sequence completed
err  out  1  sticky error
wr_reject  out  1  one-cycle pulse, CPU write dropped
frame_cnt  out  FRAME_WIDTH  frames completed in current sequence

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Reset mid-sequence abandons it with no done pulse.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, GAP, DONE, ERR.
- IDLE:
  - cpu_wr is forwarded with 1-cycle latency: mem_wr/mem_adr/mem_data are registered copies.
  - cpu_run with cpu_frames!=0: latch cpu_frames, clear frame_cnt and err, go to START.
  - cpu_run with cpu_frames==0: done pulses next cycle; stay IDLE.
  - cpu_wr and cpu_run in the same cycle: the write is forwarded and the run is accepted.
- START: mem_start=1 for exactly one cycle; clear beat and timeout counters; go to WAIT.
- WAIT:
  - Each mem_vo=1 cycle increments the beat counter (saturates at all-ones).
  - Timeout counter increments every cycle.
  - On mem_fo=1:
    - If beats != DATA_NUM: go to ERR.
    - Otherwise increment frame_cnt. If the new frame_cnt equals the latched frames, go to DONE; else go to GAP.
  - If the timeout counter reaches TIMEOUT before fo: go to ERR.
  - fo and timeout in the same cycle: fo wins.
- GAP: wait GAP cycles, then go to START.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err is set; one cycle later go to IDLE. err stays set until the next accepted cpu_run or reset.
- busy=1 in START, WAIT, GAP and DONE; 0 in IDLE and ERR.
- cpu_wr while busy: not forwarded (mem_wr stays 0); wr_reject pulses next cycle.
- cpu_abort in any non-IDLE state:
  - Go to IDLE next cycle; no done pulse, err unchanged.
  - If it coincides with fo in WAIT, the abort wins and frame_cnt is not incremented.
  - cpu_abort in IDLE is ignored.
- cpu_run while busy: ignored.
- frame_cnt holds its final value in IDLE until the next accepted cpu_run.

Decomposition:
- Shared package nps_pkg:
  - FSM state encoding constants (IDLE..ERR).
  - Default DATA_WIDTH/ADR_WIDTH so the sequencer and the memory agree.
- One natural sub-module, nps_cpu_wr_gate: registers the CPU write path and applies the busy gate, producing mem_wr/mem_adr/mem_data and wr_reject. The FSM and counters stay in the top module.

Test Plan:
- Load then run: write addrs 0..29 in IDLE (mem_wr mirrors each write 1 cycle later), then cpu_run with cpu_frames=3 and the memory model giving 30 vo beats + fo per frame -> 3 mem_start pulses each spaced >= GAP idle cycles apart, frame_cnt=3, one done pulse, err=0, busy drops after done.
- Zero frames: cpu_run with cpu_frames=0 -> no mem_start; done pulses next cycle; busy stays 0.
- Write during busy: cpu_wr at adr 5 in WAIT -> mem_wr stays 0; wr_reject pulses once; a write in IDLE afterwards is forwarded normally.
- Beat mismatch: model gives 29 vo beats then fo -> err=1, no done, busy=0; next cpu_run clears err.
- Timeout: model never asserts fo -> err set exactly TIMEOUT cycles after entering WAIT; FSM returns to IDLE.
- Abort/reset: cpu_abort in GAP of frame 2 of 4 -> IDLE, frame_cnt=1, no done, no further mem_start. reset_x low mid-WAIT -> all outputs 0 immediately (asynchronously).
